// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Purpose  : Iterative restoring divider, one quotient bit per clock.
//            Signed or unsigned operation, divide-by-zero detection and
//            cancellation of an operation in progress.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            signed_i                  - 1 = signed, 0 = unsigned
//            opdata1_i / opdata2_i     - dividend / divisor
//            start_i                   - request, held until result consumed
//            annul_i                   - cancel operation in progress
//            result_o                  - {remainder, quotient}
//            ready_o, busy_o           - result valid / not idle
//            div_zero_o                - divisor was zero
// Revision : 1.0 - initial release
// ============================================================================
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 div_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ZERO = 2'd1,
    ST_ON   = 2'd2,
    ST_END  = 2'd3
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH:0]     work;      // {partial remainder (W+1), dividend/quotient (W)}
  logic [WIDTH-1:0]     divisor;   // divisor magnitude
  logic                 is_signed;
  logic                 neg_dvd;
  logic                 neg_dvs;

  // Operand magnitudes at capture time
  logic                 neg1;
  logic                 neg2;
  logic [WIDTH-1:0]     mag1;
  logic [WIDTH-1:0]     mag2;

  assign neg1 = signed_i & opdata1_i[WIDTH-1];
  assign neg2 = signed_i & opdata2_i[WIDTH-1];
  assign mag1 = neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
  assign mag2 = neg2 ? (~opdata2_i + 1'b1) : opdata2_i;

  // One restoring step: shift left, trial-subtract the divisor from the
  // upper W+1 bits; the extra top bit of the difference is the borrow.
  logic [2*WIDTH:0]     shifted;
  logic [WIDTH+1:0]     trial;
  logic                 borrow;
  logic [2*WIDTH:0]     step_next;

  assign shifted   = work << 1;
  assign trial     = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor};
  assign borrow    = trial[WIDTH+1];
  assign step_next = borrow ? shifted
                            : ({trial[WIDTH:0], shifted[WIDTH-1:0]} |
                               {{(2*WIDTH){1'b0}}, 1'b1});

  // Sign correction applied once the magnitude division is complete
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     fin_q;
  logic [WIDTH-1:0]     fin_r;

  assign quo   = work[WIDTH-1:0];
  assign rem   = work[2*WIDTH-1:WIDTH];
  assign fin_q = (is_signed & (neg_dvd ^ neg_dvs)) ? (~quo + 1'b1) : quo;
  assign fin_r = (is_signed & neg_dvd) ? (~rem + 1'b1) : rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      work       <= '0;
      divisor    <= '0;
      is_signed  <= 1'b0;
      neg_dvd    <= 1'b0;
      neg_dvs    <= 1'b0;
      result_o   <= '0;
      ready_o    <= 1'b0;
      busy_o     <= 1'b0;
      div_zero_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i && !annul_i) begin
            is_signed <= signed_i;
            neg_dvd   <= neg1;
            neg_dvs   <= neg2;
            divisor   <= mag2;
            cnt       <= '0;
            busy_o    <= 1'b1;
            if (opdata2_i == '0) begin
              // Raw dividend parked in the low half; it becomes the remainder
              work  <= {{(WIDTH+1){1'b0}}, opdata1_i};
              state <= ST_ZERO;
            end else begin
              work  <= {{(WIDTH+1){1'b0}}, mag1};
              state <= ST_ON;
            end
          end
        end

        ST_ZERO: begin
          result_o   <= {work[WIDTH-1:0], {WIDTH{1'b1}}};
          ready_o    <= 1'b1;
          div_zero_o <= 1'b1;
          state      <= ST_END;
        end

        ST_ON: begin
          if (annul_i) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_o <= 1'b0;
          end else if (cnt == CNT_DONE) begin
            result_o <= {fin_r, fin_q};
            ready_o  <= 1'b1;
            state    <= ST_END;
          end else begin
            work <= step_next;
            cnt  <= cnt + 1'b1;
          end
        end

        ST_END: begin
          if (!start_i) begin
            state      <= ST_IDLE;
            result_o   <= '0;
            ready_o    <= 1'b0;
            div_zero_o <= 1'b0;
            busy_o     <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter
// Purpose  : Self-checking bench for div_iter (WIDTH=32 and WIDTH=8 instances)
//            with a queue-based scoreboard of expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;

  logic        sgn32, start32, annul32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic        ready32, busy32, dz32;

  logic        sgn8, start8, annul8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        ready8, busy8, dz8;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(32)) u_div32 (
    .clk(clk), .rst(rst), .signed_i(sgn32), .opdata1_i(a32), .opdata2_i(b32),
    .start_i(start32), .annul_i(annul32), .result_o(res32), .ready_o(ready32),
    .busy_o(busy32), .div_zero_o(dz32)
  );

  div_iter #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst(rst), .signed_i(sgn8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(start8), .annul_i(annul8), .result_o(res8), .ready_o(ready8),
    .busy_o(busy8), .div_zero_o(dz8)
  );

  typedef struct {
    logic [63:0] res;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs_res(input bit use8);
    return use8 ? {48'd0, res8} : res32;
  endfunction
  function automatic logic obs_ready(input bit use8);
    return use8 ? ready8 : ready32;
  endfunction
  function automatic logic obs_busy(input bit use8);
    return use8 ? busy8 : busy32;
  endfunction
  function automatic logic obs_dz(input bit use8);
    return use8 ? dz8 : dz32;
  endfunction

  // Reference model built on the simulator's own / and % operators
  function automatic exp_t model(input int w, input bit sgn, input logic [63:0] a,
                                 input logic [63:0] b);
    exp_t        e;
    logic [63:0] mask;
    logic [63:0] q;
    logic [63:0] r;
    longint      sa;
    longint      sb_v;
    mask = (64'd1 << w) - 64'd1;
    if ((b & mask) == 64'd0) begin
      q    = mask;
      r    = a & mask;
      e.dz = 1'b1;
      e.lat = 1;
    end else begin
      if (sgn) begin
        sa   = longint'(a << (64 - w)) >>> (64 - w);
        sb_v = longint'(b << (64 - w)) >>> (64 - w);
        q    = 64'(sa / sb_v) & mask;
        r    = 64'(sa % sb_v) & mask;
      end else begin
        q = (a & mask) / (b & mask);
        r = (a & mask) % (b & mask);
      end
      e.dz  = 1'b0;
      e.lat = w + 1;
    end
    e.res = (r << w) | q;
    return e;
  endfunction

  task automatic run_op(input bit use8, input bit sgn, input logic [63:0] a,
                        input logic [63:0] b);
    exp_t e;
    int   n;
    bit   seen;
    sb.push_back(model(use8 ? 8 : 32, sgn, a, b));
    @(negedge clk);
    if (use8) begin
      sgn8 = sgn; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
    end else begin
      sgn32 = sgn; a32 = a[31:0]; b32 = b[31:0]; start32 = 1'b1;
    end
    @(posedge clk);
    #1;
    // Operands are scrambled after capture; the result must not change
    a32 = $urandom; b32 = $urandom; sgn32 = ~sgn32;
    a8  = 8'($urandom); b8 = 8'($urandom); sgn8 = ~sgn8;
    check("busy_after_capture", 64'(obs_busy(use8)), 64'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      seen = obs_ready(use8);
    end
    e = sb.pop_front();
    check("latency", 64'(n), 64'(e.lat));
    check("result", obs_res(use8), e.res);
    check("div_zero", 64'(obs_dz(use8)), 64'(e.dz));
    @(posedge clk);
    #1;
    check("hold_result", obs_res(use8), e.res);
    check("hold_ready", 64'(obs_ready(use8)), 64'd1);
    @(negedge clk);
    start32 = 1'b0;
    start8  = 1'b0;
    @(posedge clk);
    #1;
    check("clear_result", obs_res(use8), 64'd0);
    check("clear_ready", 64'(obs_ready(use8)), 64'd0);
    check("clear_busy", 64'(obs_busy(use8)), 64'd0);
    check("clear_dz", 64'(obs_dz(use8)), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit rdy_seen;
    rst = 1'b1;
    sgn32 = 1'b0; start32 = 1'b0; annul32 = 1'b0; a32 = '0; b32 = '0;
    sgn8  = 1'b0; start8  = 1'b0; annul8  = 1'b0; a8  = '0; b8  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res32", res32, 64'd0);
    check("rst_ready32", 64'(ready32), 64'd0);
    check("rst_busy32", 64'(busy32), 64'd0);
    check("rst_dz32", 64'(dz32), 64'd0);
    check("rst_res8", {48'd0, res8}, 64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    rst = 1'b0;

    // First request lands on the first edge with rst low
    run_op(1'b0, 1'b1, 64'hFFFFFFF9, 64'h2);
    run_op(1'b0, 1'b0, 64'hFFFFFFFF, 64'h10);
    run_op(1'b0, 1'b1, 64'hFFFFFFFF, 64'h10);
    run_op(1'b0, 1'b0, 64'd100, 64'd0);
    run_op(1'b0, 1'b1, 64'hFFFFFFF0, 64'd0);
    run_op(1'b0, 1'b1, 64'h80000000, 64'hFFFFFFFF);
    run_op(1'b0, 1'b0, 64'd7, 64'd9);

    // annul in IDLE blocks capture
    @(negedge clk);
    start32 = 1'b1; annul32 = 1'b1; a32 = 32'd50; b32 = 32'd5;
    @(posedge clk);
    #1;
    check("annul_idle_busy", 64'(busy32), 64'd0);
    @(negedge clk);
    start32 = 1'b0; annul32 = 1'b0;

    // annul mid-operation
    @(negedge clk);
    start32 = 1'b1; sgn32 = 1'b0; a32 = 32'd1000; b32 = 32'd3;
    @(posedge clk);
    rdy_seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      rdy_seen |= ready32;
    end
    @(negedge clk);
    annul32 = 1'b1; start32 = 1'b0;
    @(posedge clk);
    #1;
    check("annul_busy", 64'(busy32), 64'd0);
    rdy_seen |= ready32;
    annul32 = 1'b0;
    @(posedge clk);
    #1;
    rdy_seen |= ready32;
    check("annul_no_ready", 64'(rdy_seen), 64'd0);
    run_op(1'b0, 1'b0, 64'd1000, 64'd3);

    // WIDTH=8 instance
    run_op(1'b1, 1'b0, 64'd200, 64'd7);
    run_op(1'b1, 1'b1, 64'h80, 64'hFF);
    run_op(1'b1, 1'b1, 64'h9C, 64'h07);
    run_op(1'b1, 1'b0, 64'hAB, 64'h00);

    // Reset mid-operation on the 8-bit instance
    @(negedge clk);
    start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd200; b8 = 8'd7;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_res8", {48'd0, res8}, 64'd0);
    check("midrst_ready8", 64'(ready8), 64'd0);
    check("midrst_busy8", 64'(busy8), 64'd0);
    check("midrst_dz8", 64'(dz8), 64'd0);
    rst = 1'b0;
    start8 = 1'b0;
    run_op(1'b1, 1'b0, 64'd200, 64'd7);

    // Random operations on the 32-bit instance
    for (int i = 0; i < 10; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      ra = 64'($urandom);
      rb = (i == 3) ? 64'd0 : 64'($urandom >> $urandom_range(0, 28));
      run_op(1'b0, 1'(i % 2), ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
